// File: rtl/instr_fetch_pkg.sv
// Shared RV32I fetch definitions: instruction constants, fetch-buffer entry layout and helpers.
package instr_fetch_pkg;

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam int unsigned ENTRY_W = 2 * XLEN;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

  function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] a);
    return {a[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// Fetch-stage bus: instruction-memory request/response, execute redirect and decode handoff.
interface instr_fetch_if;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_instr;
  logic [31:0] id_pc;

  modport master (
    output imem_req_valid, imem_req_addr, id_valid, id_instr, id_pc,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc, id_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr, id_valid, id_instr, id_pc,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc, id_ready
  );
endinterface

// File: rtl/instr_fetch_fifo.sv
// Synchronous fetch buffer holding {pc, instr} entries; flush empties it in one cycle.
module instr_fetch_fifo
  import instr_fetch_pkg::*;
#(
  parameter int unsigned WIDTH = ENTRY_W,
  parameter int unsigned DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_data,
  input  logic                     i_pop,
  input  logic                     i_flush,
  output logic [WIDTH-1:0]         o_data,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_empty,
  output logic                     o_full
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_pop;

  assign w_pop   = i_pop && !o_empty;
  assign o_data  = r_mem[r_rd_ptr];
  assign o_count = r_count;
  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == CW'(DEPTH));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= r_count + CW'(i_push) - CW'(w_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (i_push && !i_flush) r_mem[r_wr_ptr] <= i_data;
  end

endmodule

// File: rtl/instr_fetch.sv
// RV32I fetch stage: PC ownership, credit-gated in-order imem requests, stale-response dropping
// after redirect, and a small buffer feeding decode.
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input logic           clk,
  input logic           rst,
  instr_fetch_if.master bus
);
  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  logic [31:0]   r_pc;
  logic [31:0]   r_rsp_pc;
  logic [CW-1:0] r_outstanding;
  logic [CW-1:0] r_drop_cnt;
  logic [CW-1:0] w_fifo_count;
  logic          w_credit;
  logic          w_fire;
  logic          w_push;
  logic          w_pop;
  logic          w_empty;
  logic          w_full;
  logic [31:0]   w_target;
  fetch_entry_t  w_head;
  fetch_entry_t  w_push_entry;

  // Credit counts words still in flight plus words buffered, so the buffer can never overflow.
  assign w_credit = ({1'b0, r_outstanding} + {1'b0, w_fifo_count}) < (CW + 1)'(FIFO_DEPTH);
  assign bus.imem_req_valid = !rst && !bus.redirect_valid && w_credit;
  assign bus.imem_req_addr  = r_pc;
  assign w_fire   = bus.imem_req_valid && bus.imem_req_ready;
  assign w_target = align_word(bus.redirect_pc);
  assign w_push   = bus.imem_rsp_valid && (r_drop_cnt == '0) && !bus.redirect_valid && !w_full;
  assign w_pop    = !w_empty && bus.id_ready;

  always_comb begin
    w_push_entry       = '0;
    w_push_entry.pc    = r_rsp_pc;
    w_push_entry.instr = bus.imem_rsp_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc          <= RESET_PC;
      r_rsp_pc      <= RESET_PC;
      r_outstanding <= '0;
      r_drop_cnt    <= '0;
    end else begin
      r_outstanding <= r_outstanding + CW'(w_fire) - CW'(bus.imem_rsp_valid);
      if (bus.redirect_valid) begin
        // Everything still in flight after this cycle's response belongs to the old path.
        r_pc       <= w_target;
        r_rsp_pc   <= w_target;
        r_drop_cnt <= r_outstanding - CW'(bus.imem_rsp_valid);
      end else begin
        if (w_fire) r_pc <= r_pc + 32'd4;
        if (w_push) r_rsp_pc <= r_rsp_pc + 32'd4;
        if (bus.imem_rsp_valid && (r_drop_cnt != '0)) r_drop_cnt <= r_drop_cnt - 1'b1;
      end
    end
  end

  instr_fetch_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_data  (w_push_entry),
    .i_pop   (w_pop),
    .i_flush (bus.redirect_valid),
    .o_data  (w_head),
    .o_count (w_fifo_count),
    .o_empty (w_empty),
    .o_full  (w_full)
  );

  assign bus.id_valid = !w_empty;
  assign bus.id_instr = w_empty ? NOP_INSTR : w_head.instr;
  assign bus.id_pc    = w_empty ? 32'h0 : w_head.pc;

endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboard bench for instr_fetch: expected request addresses and decode entries are queued by
// the stimulus and popped by monitors as the DUT presents them.
module tb_instr_fetch;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  instr_fetch_if ifa ();
  instr_fetch_if ifb ();

  instr_fetch #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(2)) u_dut (
    .clk (clk), .rst (rst), .bus (ifa.master));
  instr_fetch #(.RESET_PC(32'hFFFF_FFF8), .FIFO_DEPTH(2)) u_dut_wrap (
    .clk (clk), .rst (rst), .bus (ifb.master));

  int vectors    = 0;
  int miscompares = 0;
  int lat        = 1;
  int cyc        = 0;

  typedef struct { logic [31:0] addr; int due; } pend_t;
  pend_t       pend_q[$];
  logic [31:0] exp_req_q[$];
  logic [31:0] exp_id_q[$];
  logic [31:0] exp_req_b[$];
  logic [31:0] exp_id_b[$];
  logic        b_fire_d = 1'b0;
  logic [31:0] b_addr_d = '0;

  function automatic logic [31:0] memw(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic extra(input string name, input logic [31:0] act);
    vectors++;
    miscompares++;
    $display("FAIL %s: got %h expected nothing (t=%0t)", name, act, $time);
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Holds id_ready high for exactly n decode handshakes, then drops it at the next cycle start.
  task automatic consume(input int n);
    int got = 0;
    int guard = 0;
    ifa.id_ready = 1'b1;
    while (got < n && guard < 60) begin
      @(negedge clk);
      if (ifa.id_valid) got++;
      guard++;
      if (got < n) begin @(posedge clk); #1; end
    end
    if (got < n) chk("consume_timeout", 32'(got), 32'(n));
    @(posedge clk); #1;
    ifa.id_ready = 1'b0;
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 30; i++) begin
      if (exp_req_q.size() == 0 && exp_id_q.size() == 0) break;
      @(posedge clk); #1;
    end
    chk({name, "_req_left"}, 32'(exp_req_q.size()), 32'd0);
    chk({name, "_id_left"},  32'(exp_id_q.size()),  32'd0);
  endtask

  // Memory model for the main DUT: in-order, fixed latency set by 'lat', reset with fetch.
  initial begin
    pend_t p;
    ifa.imem_rsp_valid = 1'b0;
    ifa.imem_rsp_data  = '0;
    forever begin
      @(posedge clk); #1;
      cyc++;
      if (!rst && pend_q.size() > 0 && pend_q[0].due <= cyc) begin
        ifa.imem_rsp_valid = 1'b1;
        ifa.imem_rsp_data  = memw(pend_q[0].addr);
        void'(pend_q.pop_front());
      end else begin
        ifa.imem_rsp_valid = 1'b0;
        ifa.imem_rsp_data  = '0;
      end
      @(negedge clk);
      if (rst) pend_q.delete();
      else if (ifa.imem_req_valid && ifa.imem_req_ready) begin
        p.addr = ifa.imem_req_addr;
        p.due  = cyc + lat;
        pend_q.push_back(p);
      end
    end
  end

  // Monitor for the main DUT.
  initial begin
    logic [31:0] e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (ifa.imem_req_valid && ifa.imem_req_ready) begin
          if (exp_req_q.size() == 0) extra("req_extra", ifa.imem_req_addr);
          else chk("req_addr", ifa.imem_req_addr, exp_req_q.pop_front());
        end
        if (ifa.id_valid && ifa.id_ready) begin
          if (exp_id_q.size() == 0) extra("id_extra", ifa.id_pc);
          else begin
            e = exp_id_q.pop_front();
            chk("id_pc", ifa.id_pc, e);
            chk("id_instr", ifa.id_instr, memw(e));
          end
        end
        if (!ifa.id_valid) begin
          chk("idle_instr_nop", ifa.id_instr, NOP);
          chk("idle_pc_zero", ifa.id_pc, 32'h0);
        end
      end
    end
  end

  // Latency-1 memory and always-ready decode for the wrap-around instance.
  initial begin
    ifb.imem_req_ready = 1'b1;
    ifb.redirect_valid = 1'b0;
    ifb.redirect_pc    = '0;
    ifb.id_ready       = 1'b1;
    ifb.imem_rsp_valid = 1'b0;
    ifb.imem_rsp_data  = '0;
    forever begin
      @(posedge clk); #1;
      ifb.imem_rsp_valid = b_fire_d && !rst;
      ifb.imem_rsp_data  = memw(b_addr_d);
      @(negedge clk);
      b_fire_d = !rst && ifb.imem_req_valid;
      b_addr_d = ifb.imem_req_addr;
    end
  end

  initial begin
    logic [31:0] e;
    forever begin
      @(negedge clk);
      if (!rst && ifb.imem_req_valid && exp_req_b.size() > 0)
        chk("wrap_req_addr", ifb.imem_req_addr, exp_req_b.pop_front());
      if (!rst && ifb.id_valid && exp_id_b.size() > 0) begin
        e = exp_id_b.pop_front();
        chk("wrap_id_pc", ifb.id_pc, e);
        chk("wrap_id_instr", ifb.id_instr, memw(e));
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish (t=%0t)", $time);
    $fatal(1);
  end

  initial begin
    ifa.imem_req_ready = 1'b1;
    ifa.redirect_valid = 1'b0;
    ifa.redirect_pc    = '0;
    ifa.id_ready       = 1'b0;
    exp_req_b = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000};
    exp_id_b  = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000};

    // Reset values.
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req_valid", 32'(ifa.imem_req_valid), 32'd0);
    chk("rst_id_valid",  32'(ifa.id_valid), 32'd0);
    chk("rst_id_instr",  ifa.id_instr, NOP);
    chk("rst_id_pc",     ifa.id_pc, 32'h0);

    // Basic stream, latency 1: three words consumed, buffer refills with two more.
    exp_req_q = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10};
    exp_id_q  = '{32'h0, 32'h4, 32'h8};
    @(posedge clk); #1;
    rst = 1'b0;
    ifa.id_ready = 1'b1;
    consume(3);
    idle(3);
    drain("stream");

    // Back-pressure: buffer full, requests stop; resume at next PC on release.
    @(negedge clk);
    chk("bp_req_stopped", 32'(ifa.imem_req_valid), 32'd0);
    @(posedge clk); #1;
    exp_req_q = '{32'h14, 32'h18};
    exp_id_q  = '{32'hC, 32'h10};
    consume(2);
    idle(3);
    drain("backpressure");

    // Redirect with two requests in flight at latency 3.
    lat = 3;
    exp_req_q = '{32'h1C, 32'h20, 32'h100, 32'h104};
    exp_id_q  = '{32'h14, 32'h18};
    consume(2);
    idle(1);
    ifa.redirect_valid = 1'b1;
    ifa.redirect_pc    = 32'h0000_0100;
    @(negedge clk);
    chk("redir_no_req", 32'(ifa.imem_req_valid), 32'd0);
    @(posedge clk); #1;
    ifa.redirect_valid = 1'b0;
    idle(10);
    drain("redirect");

    // Misaligned redirect coincident with a decode handshake and a memory response.
    lat = 1;
    exp_req_q = '{32'h108, 32'h10C, 32'h100, 32'h104};
    exp_id_q  = '{32'h100, 32'h104, 32'h108};
    ifa.id_ready = 1'b1;
    idle(3);
    ifa.redirect_valid = 1'b1;
    ifa.redirect_pc    = 32'h0000_0103;
    @(negedge clk);
    chk("redir_hs_pc", ifa.id_pc, 32'h108);
    @(posedge clk); #1;
    ifa.redirect_valid = 1'b0;
    ifa.id_ready       = 1'b0;
    @(negedge clk);
    chk("misalign_req_valid", 32'(ifa.imem_req_valid), 32'd1);
    chk("misalign_req_addr",  ifa.imem_req_addr, 32'h100);
    @(posedge clk); #1;
    idle(5);
    drain("misalign");

    // Memory stall: request held with a stable address.
    ifa.imem_req_ready = 1'b0;
    exp_req_q = '{32'h108, 32'h10C};
    exp_id_q  = '{32'h100, 32'h104};
    consume(2);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_req_valid", 32'(ifa.imem_req_valid), 32'd1);
      chk("stall_req_addr",  ifa.imem_req_addr, 32'h108);
      @(posedge clk); #1;
    end
    ifa.imem_req_ready = 1'b1;
    idle(5);
    drain("stall");

    // Reset with a full buffer clears outputs immediately, then restarts from RESET_PC.
    @(negedge clk);
    chk("full_id_valid", 32'(ifa.id_valid), 32'd1);
    chk("full_id_pc",    ifa.id_pc, 32'h108);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("midrst_id_valid",  32'(ifa.id_valid), 32'd0);
    chk("midrst_id_instr",  ifa.id_instr, NOP);
    chk("midrst_id_pc",     ifa.id_pc, 32'h0);
    chk("midrst_req_valid", 32'(ifa.imem_req_valid), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    exp_req_q = '{32'h0, 32'h4, 32'h8, 32'hC};
    exp_id_q  = '{32'h0, 32'h4};
    rst = 1'b0;
    ifa.id_ready = 1'b1;
    consume(2);
    idle(5);
    drain("restart");

    chk("wrap_req_left", 32'(exp_req_b.size()), 32'd0);
    chk("wrap_id_left",  32'(exp_id_b.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
